// File: rtl/fifo_burst_pkg.sv
// -----------------------------------------------------------------------------
// fifo_burst_pkg
// Shared types and constants for the FIFO burst reader and its output buffer.
//   state_t   : burst reader FSM states (IDLE / BURST)
//   BUF_DEPTH : number of entries in the output stream buffer
// -----------------------------------------------------------------------------
package fifo_burst_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // Three entries cover the one-cycle FIFO read latency plus the word being
    // presented, which is what lets a burst stream one word per cycle.
    localparam int BUF_DEPTH = 3;

endpackage

// File: rtl/stream_buf.sv
// -----------------------------------------------------------------------------
// stream_buf
// Small circular buffer holding data words plus their end-of-burst flag.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_push          : write i_data/i_last into the tail
//   i_data, i_last  : word and last flag to store
//   i_pop           : drop the head entry (ignored when empty)
//   o_data, o_last  : head entry, held stable until popped
//   o_count         : number of valid entries
// -----------------------------------------------------------------------------
module stream_buf
    import fifo_burst_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = BUF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_last,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_last,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH:0]  r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_pop;
    logic            w_push;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

    // Storage, pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {i_last, i_data};
                r_wr_ptr        <= nextPtr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= nextPtr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign {o_last, o_data} = r_mem[r_rd_ptr];
    assign o_count          = r_count;

endmodule

// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
// Drains an upstream synchronous FIFO in bursts onto a valid/ready stream.
// A full burst of BURST_LEN words starts as soon as that many are available;
// a shorter burst of whatever is present is forced after TIMEOUT idle cycles.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   fifo_rd_en     : read strobe to the FIFO (data returns one cycle later)
//   fifo_rd_data   : FIFO read data
//   fifo_empty     : FIFO empty flag
//   fifo_data_cnt  : FIFO occupancy
//   m_valid/m_ready: output stream handshake
//   m_data, m_last : output word and end-of-burst marker
//   busy           : high while a burst is in progress
//   burst_count    : completed bursts, wraps at 2^16
// -----------------------------------------------------------------------------
module fifo_burst_reader
    import fifo_burst_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 128,
    parameter int BURST_LEN = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     fifo_rd_en,
    input  logic [WIDTH-1:0]         fifo_rd_data,
    input  logic                     fifo_empty,
    input  logic [$clog2(DEPTH)-1:0] fifo_data_cnt,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [WIDTH-1:0]         m_data,
    output logic                     m_last,
    output logic                     busy,
    output logic [15:0]              burst_count
);
    localparam int LW = $clog2(BURST_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int OW = $clog2(BUF_DEPTH + 1);
    localparam int PW = OW + 1;

    state_t          r_state;
    logic [LW-1:0]   r_len;
    logic [LW-1:0]   r_issued;
    logic [TW-1:0]   r_timer;
    logic            r_inflight;
    logic            r_inflight_last;
    logic            r_busy;
    logic [15:0]     r_burst_count;

    logic [OW-1:0]   w_occ;
    logic [PW-1:0]   w_pending;
    logic            w_start_full;
    logic            w_start_timeout;
    logic            w_pop;
    logic            w_last_accept;

    assign w_pop           = m_valid && m_ready;
    assign w_last_accept   = w_pop && m_last;
    assign w_start_full    = 32'(fifo_data_cnt) >= BURST_LEN;
    assign w_start_timeout = !fifo_empty && (r_timer == TW'(TIMEOUT - 1));

    // Words already buffered plus the read still returning; only registered
    // terms are used so the read strobe never depends on m_ready.
    assign w_pending  = PW'(w_occ) + PW'(r_inflight);
    assign fifo_rd_en = (r_state == ST_BURST) && (r_issued < r_len) && !fifo_empty
                        && (w_pending <= PW'(BUF_DEPTH - 1));

    assign m_valid     = (w_occ != '0);
    assign busy        = r_busy;
    assign burst_count = r_burst_count;

    // Burst sequencing: start decision and length latch in IDLE, read issue
    // tracking in BURST, and return to IDLE when the last word is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_len           <= '0;
            r_issued        <= '0;
            r_timer         <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_busy          <= 1'b0;
            r_burst_count   <= '0;
        end else begin
            r_inflight      <= fifo_rd_en;
            r_inflight_last <= fifo_rd_en && ((r_issued + LW'(1)) == r_len);
            case (r_state)
                ST_IDLE: begin
                    r_issued <= '0;
                    if (w_start_full) begin
                        r_state <= ST_BURST;
                        r_busy  <= 1'b1;
                        r_len   <= LW'(BURST_LEN);
                        r_timer <= '0;
                    end else if (w_start_timeout) begin
                        // Fewer than BURST_LEN words here, so the count fits r_len.
                        r_state <= ST_BURST;
                        r_busy  <= 1'b1;
                        r_len   <= LW'(fifo_data_cnt);
                        r_timer <= '0;
                    end else if (fifo_empty) begin
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_BURST: begin
                    r_timer <= '0;
                    if (fifo_rd_en) begin
                        r_issued <= r_issued + LW'(1);
                    end
                    if (w_last_accept) begin
                        r_state       <= ST_IDLE;
                        r_busy        <= 1'b0;
                        r_burst_count <= r_burst_count + 16'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    stream_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_inflight),
        .i_data  (fifo_rd_data),
        .i_last  (r_inflight_last),
        .i_pop   (w_pop),
        .o_data  (m_data),
        .o_last  (m_last),
        .o_count (w_occ)
    );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_burst_reader
// Drives fifo_burst_reader from a behavioural upstream FIFO and checks the
// output stream against a burst-plan model of what the reader should emit.
// -----------------------------------------------------------------------------
module tb_fifo_burst_reader;
    localparam int WIDTH     = 8;
    localparam int DEPTH     = 128;
    localparam int BURST_LEN = 16;
    localparam int TIMEOUT   = 64;
    localparam int CNTW      = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_rd_data;
    logic             fifo_empty;
    logic [CNTW-1:0]  fifo_data_cnt;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             busy;
    logic [15:0]      burst_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Upstream FIFO storage
    logic [WIDTH-1:0] fifoMem [1024];
    int wrPtr = 0;
    int rdPtr = 0;

    // Model and monitor state
    logic [WIDTH:0] expQ[$];
    logic [WIDTH:0] gotQ[$];
    int             gotCyc[$];
    int expBursts    = 0;
    int firstRd      = -1;
    int firstValid   = -1;
    int rdWhileEmpty = 0;
    int overOcc      = 0;
    int stallBad     = 0;
    int rdTotal      = 0;
    int accTotal     = 0;
    bit prevStall    = 1'b0;
    logic [WIDTH-1:0] prevData;
    logic             prevLast;

    fifo_burst_reader #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .BURST_LEN (BURST_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_empty    (fifo_empty),
        .fifo_data_cnt (fifo_data_cnt),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_last        (m_last),
        .busy          (busy),
        .burst_count   (burst_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous FIFO: read data appears the cycle after the strobe; reset flushes it.
    assign fifo_empty    = (wrPtr == rdPtr);
    assign fifo_data_cnt = CNTW'(wrPtr - rdPtr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr        <= wrPtr;
            fifo_rd_data <= '0;
        end else if (fifo_rd_en && (rdPtr != wrPtr)) begin
            fifo_rd_data <= fifoMem[rdPtr % 1024];
            rdPtr        <= rdPtr + 1;
        end
    end

    // Observe the stream mid-cycle: record accepted words and track invariants.
    always @(negedge clk) begin
        if (!rst_n) begin
            rdTotal   = 0;
            accTotal  = 0;
            prevStall = 1'b0;
        end else begin
            if (fifo_rd_en && fifo_empty) rdWhileEmpty++;
            if (rdTotal - accTotal > 3) overOcc++;
            if (prevStall && !(m_valid && (m_data == prevData) && (m_last == prevLast))) stallBad++;
            if (fifo_rd_en && firstRd < 0) firstRd = cyc;
            if (m_valid && firstValid < 0) firstValid = cyc;
            if (fifo_rd_en) rdTotal++;
            if (m_valid && m_ready) begin
                gotQ.push_back({m_last, m_data});
                gotCyc.push_back(cyc);
                accTotal++;
            end
            prevStall = m_valid && !m_ready;
            prevData  = m_data;
            prevLast  = m_last;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Preload n words and extend the expected stream: full bursts while at
    // least BURST_LEN words remain, then one forced burst of the remainder.
    task automatic applyStimulus(input int n, input bit seqMode);
        int rem;
        int idx;
        int len;
        logic [WIDTH-1:0] d;
        rem = n;
        idx = 0;
        while (rem > 0) begin
            len = (rem >= BURST_LEN) ? BURST_LEN : rem;
            for (int j = 0; j < len; j++) begin
                d = seqMode ? WIDTH'(idx) : WIDTH'($urandom);
                fifoMem[wrPtr % 1024] = d;
                wrPtr++;
                expQ.push_back({(j == len - 1), d});
                idx++;
            end
            expBursts++;
            rem -= len;
        end
    endtask

    // mode 0: always ready, 1: toggling 1,0,..., other: random
    task automatic waitBursts(input int target, input int budget, input int mode);
        int n;
        bit ph;
        n  = 0;
        ph = 1'b1;
        while ((burst_count !== 16'(target)) && (n < budget)) begin
            @(posedge clk);
            #1;
            ph = ~ph;
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ph;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            n++;
        end
    endtask

    task automatic checkStream(input string tag);
        checkOutput({tag, " count"}, gotQ.size(), expQ.size());
        for (int i = 0; i < expQ.size(); i++) begin
            if (i < gotQ.size()) begin
                checkOutput($sformatf("%s word%0d", tag, i), 32'(gotQ[i]), 32'(expQ[i]));
            end
        end
        gotQ.delete();
        gotCyc.delete();
        expQ.delete();
    endtask

    task automatic startStep();
        firstRd    = -1;
        firstValid = -1;
        overOcc    = 0;
        stallBad   = 0;
        gotQ.delete();
        gotCyc.delete();
    endtask

    initial begin
        int c0;
        int n;

        rst_n   = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset rd_en", fifo_rd_en, 0);
        checkOutput("reset m_valid", m_valid, 0);
        checkOutput("reset m_data", m_data, 0);
        checkOutput("reset m_last", m_last, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset burst_count", burst_count, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] empty FIFO for 200 cycles");
        startStep();
        repeat (200) begin
            @(posedge clk);
            #1;
            m_ready = 1'($urandom_range(0, 1));
        end
        checkOutput("empty no read", firstRd, -1);
        checkOutput("empty no valid", firstValid, -1);
        checkOutput("empty busy", busy, 0);

        $display("[TB] 5 words, timeout burst");
        startStep();
        m_ready = 1'b1;
        c0 = cyc;
        applyStimulus(5, 1'b0);
        waitBursts(expBursts, 300, 0);
        checkOutput("timeout first read", firstRd, c0 + TIMEOUT);
        checkOutput("timeout first valid", firstValid, c0 + TIMEOUT + 2);
        checkOutput("timeout burst_count", burst_count, expBursts);
        checkStream("timeout");

        $display("[TB] 16 words, full burst latency");
        startStep();
        c0 = cyc;
        applyStimulus(16, 1'b1);
        waitBursts(expBursts, 200, 0);
        checkOutput("full first read", firstRd, c0 + 1);
        checkOutput("full first valid", firstValid, c0 + 3);
        if (gotCyc.size() >= 16) begin
            checkOutput("full back-to-back", gotCyc[15] - gotCyc[0], 15);
        end
        checkOutput("full burst_count", burst_count, expBursts);
        checkStream("full");

        $display("[TB] 40 words, 16+16+8");
        startStep();
        applyStimulus(40, 1'b0);
        waitBursts(expBursts, 600, 0);
        checkOutput("split burst_count", burst_count, expBursts);
        if (gotCyc.size() >= 40) begin
            checkOutput("split gap 1-2", gotCyc[16] - gotCyc[15], 4);
            checkOutput("split burst2 rate", gotCyc[31] - gotCyc[16], 15);
            checkOutput("split gap 2-3", gotCyc[32] - gotCyc[31], TIMEOUT + 3);
        end
        checkStream("split");

        $display("[TB] 16 words, toggling ready");
        startStep();
        m_ready = 1'b1;
        applyStimulus(16, 1'b0);
        waitBursts(expBursts, 300, 1);
        checkOutput("toggle burst_count", burst_count, expBursts);
        checkOutput("toggle stall stable", stallBad, 0);
        checkOutput("toggle occupancy", overOcc, 0);
        checkStream("toggle");

        $display("[TB] random length, random ready");
        startStep();
        n = $urandom_range(1, 60);
        applyStimulus(n, 1'b0);
        waitBursts(expBursts, 2000, 2);
        checkOutput("random burst_count", burst_count, expBursts);
        checkOutput("random stall stable", stallBad, 0);
        checkOutput("random occupancy", overOcc, 0);
        checkStream("random");

        $display("[TB] reset mid-burst");
        startStep();
        expQ.delete();
        m_ready = 1'b1;
        applyStimulus(16, 1'b0);
        for (int k = 0; (k < 100) && (gotQ.size() < 7); k++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("abort words before reset", gotQ.size(), 7);
        rst_n     = 1'b0;
        expBursts = 0;
        @(negedge clk);
        checkOutput("abort rd_en", fifo_rd_en, 0);
        checkOutput("abort m_valid", m_valid, 0);
        checkOutput("abort m_data", m_data, 0);
        checkOutput("abort m_last", m_last, 0);
        checkOutput("abort busy", busy, 0);
        checkOutput("abort burst_count", burst_count, 0);
        for (int i = 0; i < gotQ.size(); i++) begin
            if (i < expQ.size()) begin
                checkOutput($sformatf("abort word%0d", i), 32'(gotQ[i]), 32'(expQ[i]));
            end
        end
        gotQ.delete();
        gotCyc.delete();
        expQ.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("post-reset m_valid", m_valid, 0);
        checkOutput("post-reset rd_en", fifo_rd_en, 0);
        checkOutput("post-reset burst_count", burst_count, 0);

        checkOutput("never read while empty", rdWhileEmpty, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
